// File: rtl/reaction_timer_multi.sv
// rtl/reaction_timer_multi.sv - reaction-time benchmark with BCD timing, best record and digit scan
// Random pre-react delay from a Galois LFSR; response timed in BCD ms, saturating at all-9s.
module reaction_timer_multi #(
   parameter int          CYCLES_PER_MS = 50,
   parameter int          DIGITS        = 4,
   parameter int          MIN_DELAY_MS  = 1000,
   parameter int          RAND_BITS     = 12,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          SCAN_DIV      = 1,
   localparam int         SW            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_trigger,
   input  logic          user_trigger,
   input  logic          clear_best,
   input  logic          show_best,
   output logic [3:0]    digit,
   output logic [SW-1:0] display_select,
   output logic          react,
   output logic          false_start,
   output logic          overflow,
   output logic          new_best,
   output logic          best_valid
);

   localparam int RW = 4 * DIGITS;
   localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
   localparam int PW = $clog2(CYCLES_PER_MS);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [RW-1:0] ALL9 = {DIGITS{4'h9}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_REACT,
      S_SHOW,
      S_FAULT
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [DW-1:0] delay_q, delay_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [RW-1:0] result_q, result_d;
   logic [RW-1:0] best_q, best_d;
   logic          overflow_q, overflow_d;
   logic          best_valid_q, best_valid_d;
   logic          new_best_q, new_best_d;
   logic [CW-1:0] scan_q, scan_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [3:0]    digit_q, digit_d;
   logic          ms_tick;
   logic [RW-1:0] disp_src;

   function automatic logic [RW-1:0] bcd_inc(input logic [RW-1:0] v);
      logic [RW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign ms_tick  = (presc_q == PW'(CYCLES_PER_MS - 1));
   assign disp_src = show_best ? best_q : result_q;

   always_comb begin
      state_d      = state_q;
      lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      delay_d      = delay_q;
      presc_d      = '0;
      result_d     = result_q;
      best_d       = best_q;
      overflow_d   = overflow_q;
      best_valid_d = best_valid_q;
      new_best_d   = 1'b0;
      scan_d       = scan_q + CW'(1);
      sel_d        = sel_q;
      digit_d      = 4'd0;

      if (scan_q == CW'(SCAN_DIV - 1)) begin
         scan_d = '0;
         sel_d  = (sel_q == SW'(DIGITS - 1)) ? '0 : sel_q + SW'(1);
      end

      for (int i = 0; i < DIGITS; i++) begin
         if (sel_q == SW'(i)) digit_d = disp_src[4*i +: 4];
      end

      case (state_q)
         S_IDLE, S_SHOW, S_FAULT: begin
            if (start_trigger) begin
               state_d    = S_WAIT;
               delay_d    = DW'(MIN_DELAY_MS) + {{(DW-RAND_BITS){1'b0}}, lfsr_q[RAND_BITS-1:0]};
               result_d   = '0;
               overflow_d = 1'b0;
               scan_d     = '0;
               sel_d      = '0;
            end
         end
         S_WAIT: begin
            presc_d = ms_tick ? '0 : presc_q + PW'(1);
            if (user_trigger) begin
               state_d = S_FAULT;
            end else if (ms_tick) begin
               delay_d = delay_q - DW'(1);
               if (delay_q == DW'(1)) state_d = S_REACT;
            end
         end
         S_REACT: begin
            presc_d = ms_tick ? '0 : presc_q + PW'(1);
            // A response freezes the count even on a tick edge.
            if (user_trigger) begin
               state_d = S_SHOW;
               if (!best_valid_q || (result_q < best_q)) begin
                  best_d       = result_q;
                  best_valid_d = 1'b1;
                  new_best_d   = 1'b1;
               end
            end else if (ms_tick) begin
               if (result_q == ALL9) begin
                  overflow_d = 1'b1;
                  state_d    = S_SHOW;
               end else begin
                  result_d = bcd_inc(result_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (clear_best) begin
         best_d       = ALL9;
         best_valid_d = 1'b0;
         new_best_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lfsr_q       <= LFSR_SEED;
         delay_q      <= '0;
         presc_q      <= '0;
         result_q     <= '0;
         best_q       <= ALL9;
         overflow_q   <= 1'b0;
         best_valid_q <= 1'b0;
         new_best_q   <= 1'b0;
         scan_q       <= '0;
         sel_q        <= '0;
         digit_q      <= 4'd0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         delay_q      <= delay_d;
         presc_q      <= presc_d;
         result_q     <= result_d;
         best_q       <= best_d;
         overflow_q   <= overflow_d;
         best_valid_q <= best_valid_d;
         new_best_q   <= new_best_d;
         scan_q       <= scan_d;
         sel_q        <= sel_d;
         digit_q      <= digit_d;
      end
   end

   assign digit          = digit_q;
   assign display_select = sel_q;
   assign react          = (state_q == S_REACT);
   assign false_start    = (state_q == S_FAULT);
   assign overflow       = overflow_q;
   assign new_best       = new_best_q;
   assign best_valid     = best_valid_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// tb/tb_reaction_timer_multi.sv - directed bench with a millisecond-level reference model
module tb_reaction_timer_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_trigger = 1'b0;
   logic       user_trigger = 1'b0;
   logic       clear_best = 1'b0;
   logic       show_best = 1'b0;
   logic [3:0] digit;
   logic [0:0] display_select;
   logic       react, false_start, overflow, new_best, best_valid;

   always #5 clk = ~clk;

   reaction_timer_multi #(
      .CYCLES_PER_MS(4),
      .DIGITS       (2),
      .MIN_DELAY_MS (2),
      .RAND_BITS    (2),
      .LFSR_SEED    (16'hACE1),
      .SCAN_DIV     (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_trigger (start_trigger),
      .user_trigger  (user_trigger),
      .clear_best    (clear_best),
      .show_best     (show_best),
      .digit         (digit),
      .display_select(display_select),
      .react         (react),
      .false_start   (false_start),
      .overflow      (overflow),
      .new_best      (new_best),
      .best_valid    (best_valid)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: mode plus elapsed-cycle counters, result/best as decimal integers.
   localparam int M_IDLE = 0, M_WAIT = 1, M_REACT = 2, M_SHOW = 3, M_FAULT = 4;
   int          m_mode, m_delay, m_wait, m_react, m_result, m_best, m_sel, m_digit;
   logic [15:0] m_lfsr;
   bit          m_ovf, m_bvalid, m_newbest;
   bit          m_ready = 1'b0;

   task automatic model_step();
      logic [15:0] old_lfsr;
      int          src;
      if (rst) begin
         m_mode = M_IDLE; m_lfsr = 16'hACE1; m_result = 0; m_best = 99;
         m_bvalid = 1'b0; m_newbest = 1'b0; m_ovf = 1'b0; m_sel = 0; m_digit = 0;
         m_delay = 0; m_wait = 0; m_react = 0;
         m_ready = 1'b1;
         return;
      end
      src       = show_best ? m_best : m_result;
      m_digit   = (m_sel == 0) ? (src % 10) : ((src / 10) % 10);
      m_sel     = (m_sel + 1) % 2;
      m_newbest = 1'b0;
      old_lfsr  = m_lfsr;
      m_lfsr    = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      case (m_mode)
         M_IDLE, M_SHOW, M_FAULT: begin
            if (start_trigger) begin
               m_mode = M_WAIT; m_delay = 2 + int'(old_lfsr[1:0]); m_wait = 0;
               m_result = 0; m_ovf = 1'b0; m_sel = 0;
            end
         end
         M_WAIT: begin
            m_wait++;
            if (user_trigger) m_mode = M_FAULT;
            else if (m_wait == 4 * m_delay) begin m_mode = M_REACT; m_react = 0; end
         end
         M_REACT: begin
            m_react++;
            if (user_trigger) begin
               m_mode = M_SHOW;
               if (!m_bvalid || m_result < m_best) begin
                  m_best = m_result; m_bvalid = 1'b1; m_newbest = 1'b1;
               end
            end else if (m_react % 4 == 0) begin
               if (m_react / 4 > 99) begin m_ovf = 1'b1; m_mode = M_SHOW; end
               else m_result = m_react / 4;
            end
         end
         default: m_mode = M_IDLE;
      endcase
      if (clear_best) begin m_best = 99; m_bvalid = 1'b0; m_newbest = 1'b0; end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (m_ready) begin
         chk("react",          32'(react),          32'(m_mode == M_REACT));
         chk("false_start",    32'(false_start),    32'(m_mode == M_FAULT));
         chk("overflow",       32'(overflow),       32'(m_ovf));
         chk("new_best",       32'(new_best),       32'(m_newbest));
         chk("best_valid",     32'(best_valid),     32'(m_bvalid));
         chk("display_select", 32'(display_select), 32'(m_sel));
         chk("digit",          32'(digit),          32'(m_digit));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_level(input logic lvl, input int limit, output int n);
      n = 0;
      while (react !== lvl && n < limit) begin
         tick();
         n++;
      end
      if (react !== lvl) begin
         n_cmp++;
         n_err++;
         $display("FAIL react_wait at %0t: react stuck at %0b, wanted %0b", $time, react, lvl);
      end
   endtask

   task automatic start_round();
      start_trigger = 1'b1;
      tick();
      start_trigger = 1'b0;
   endtask

   initial begin
      int   n, d;
      logic [3:0] a, b;
      logic [3:0] seq [4];
      int   exp2 [4];
      exp2 = '{7, 0, 7, 0};

      repeat (3) tick();
      chk("reset_digit", 32'(digit), 0);
      chk("reset_best_valid", 32'(best_valid), 0);
      rst = 1'b0;

      // Round 1: seed 0xACE1 gives lfsr[1:0]=1, delay 3 ms, react after 12 cycles.
      start_round();
      wait_level(1'b1, 40, n);
      chk("t1_react_latency", n, 12);
      chk("t1_latency_vs_model", n, 4 * m_delay);
      repeat (28) tick();
      user_trigger = 1'b1; tick(); user_trigger = 1'b0;
      chk("t2_new_best", 32'(new_best), 1);
      chk("t2_best_valid", 32'(best_valid), 1);
      chk("t2_react_low", 32'(react), 0);
      seq[0] = digit;
      for (int i = 1; i < 4; i++) begin tick(); seq[i] = digit; end
      for (int i = 0; i < 4; i++) chk("t2_digit_seq", 32'(seq[i]), exp2[i]);

      // Round 2: 12 ms response is not a new best.
      start_round();
      wait_level(1'b1, 40, n);
      chk("t3_latency", n, 4 * m_delay);
      repeat (48) tick();
      user_trigger = 1'b1; tick(); user_trigger = 1'b0;
      chk("t3_no_new_best", 32'(new_best), 0);
      tick(); a = digit; tick(); b = digit;
      chk("t3_result_12", 32'((a == 2 && b == 1) || (a == 1 && b == 2)), 1);
      show_best = 1'b1;
      tick(); tick(); a = digit; tick(); b = digit;
      chk("t3_best_07", 32'((a == 7 && b == 0) || (a == 0 && b == 7)), 1);

      // False starts: mid-wait and on the exact expiry edge.
      start_round();
      repeat (3) tick();
      user_trigger = 1'b1; tick(); user_trigger = 1'b0;
      chk("t4_false_start_mid", 32'(false_start), 1);
      repeat (10) tick();
      chk("t4_react_low_mid", 32'(react), 0);
      start_round();
      d = m_delay;
      repeat (4 * d - 1) tick();
      user_trigger = 1'b1; tick(); user_trigger = 1'b0;
      chk("t4_false_start_expiry", 32'(false_start), 1);
      chk("t4_react_low_expiry", 32'(react), 0);
      repeat (8) tick();
      chk("t4_best_kept", 32'(best_valid), 1);
      show_best = 1'b0;

      // No response: saturates at 99 after 400 cycles.
      start_round();
      wait_level(1'b1, 40, n);
      wait_level(1'b0, 500, n);
      chk("t5_react_cycles", n, 400);
      chk("t5_overflow", 32'(overflow), 1);
      chk("t5_no_new_best", 32'(new_best), 0);
      tick(); a = digit; tick(); b = digit;
      chk("t5_digit_a", 32'(a), 9);
      chk("t5_digit_b", 32'(b), 9);

      // Reset mid-REACT.
      start_round();
      wait_level(1'b1, 40, n);
      repeat (5) tick();
      rst = 1'b1; tick();
      chk("t6_react", 32'(react), 0);
      chk("t6_best_valid", 32'(best_valid), 0);
      chk("t6_digit", 32'(digit), 0);
      chk("t6_overflow", 32'(overflow), 0);
      rst = 1'b0;

      // Response on the first REACT cycle, then clear_best in SHOW.
      start_round();
      wait_level(1'b1, 40, n);
      chk("t6_latency_after_reset", n, 12);
      user_trigger = 1'b1; tick(); user_trigger = 1'b0;
      chk("t6_first_cycle_new_best", 32'(new_best), 1);
      tick(); a = digit; tick(); b = digit;
      chk("t6_result_zero", 32'(a + b), 0);
      clear_best = 1'b1; tick(); clear_best = 1'b0;
      chk("t6_cleared", 32'(best_valid), 0);

      // clear_best on the same edge as a record update wins.
      start_round();
      wait_level(1'b1, 40, n);
      repeat (4) tick();
      user_trigger = 1'b1; clear_best = 1'b1; tick();
      user_trigger = 1'b0; clear_best = 1'b0;
      chk("t6_override_new_best", 32'(new_best), 0);
      chk("t6_override_valid", 32'(best_valid), 0);
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
